// File: rtl/fetch_unit_if.sv
// Program-memory fetch bus: byte-wide read with a req/ack handshake.
//   mem_req  : fetch side requests a read at mem_addr (held until ack)
//   mem_addr : read address, stable while mem_req is high
//   mem_ack  : memory acknowledge; mem_data is valid in the same cycle
//   mem_data : read data byte
// Modports: master = fetch unit, slave = program memory.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [7:0]            mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches opcode bytes from program
// memory over a req/ack bus and loads them into IR for the control unit.
// Optional one-byte prefetch buffer enabled by defining FETCH_PREFETCH_EN.
// Ports:
//   clock, reset  : clock, asynchronous active-low reset
//   ir_load       : fetch request pulse from the control unit
//   pc_load/pc_in : jump/branch target load
//   mem           : program memory bus (fetch_unit_if.master)
//   IR, ir_valid  : instruction register and its one-cycle update pulse
//   pc            : address of the next byte to be delivered to IR
//   busy          : an accepted demand fetch is still outstanding
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ir_load,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  fetch_unit_if.master          mem,
  output logic [7:0]            IR,
  output logic                  ir_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

`ifdef FETCH_PREFETCH_EN
  typedef enum logic [1:0] {IDLE, FETCH_REQ, PF_REQ} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH_REQ} state_t;
`endif

  state_t                state;
  logic                  jump_pend;
  logic [ADDR_WIDTH-1:0] jump_target;
`ifdef FETCH_PREFETCH_EN
  logic [7:0]            pf_data;
  logic                  pf_valid;
`endif

  logic                  jump_now;
  logic [ADDR_WIDTH-1:0] jump_tgt;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  demand;

  // A jump arriving in the same cycle as the ack takes effect immediately.
  always_comb begin
    jump_now   = pc_load | jump_pend;
    jump_tgt   = pc_load ? pc_in : jump_target;
    pc_inc     = pc + PC_ONE;
    issue_addr = pc_load ? pc_in : pc;
`ifdef FETCH_PREFETCH_EN
    // A demand raised during a prefetch is served by that prefetch's ack.
    demand     = busy | ((state == PF_REQ) & ir_load);
`else
    demand     = busy;
`endif
  end

  // Fetch FSM and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= PC_RST;
      mem.mem_addr <= PC_RST;
      mem.mem_req  <= 1'b0;
      IR           <= 8'h00;
      ir_valid     <= 1'b0;
      busy         <= 1'b0;
      jump_pend    <= 1'b0;
      jump_target  <= PC_RST;
`ifdef FETCH_PREFETCH_EN
      pf_data      <= 8'h00;
      pf_valid     <= 1'b0;
`endif
    end else begin
      ir_valid <= 1'b0;
      case (state)
        IDLE: begin
`ifdef FETCH_PREFETCH_EN
          if (ir_load && !pc_load && pf_valid) begin
            // Serve from the buffer and immediately refill it.
            IR           <= pf_data;
            ir_valid     <= 1'b1;
            pc           <= pc_inc;
            pf_valid     <= 1'b0;
            mem.mem_addr <= pc_inc;
            mem.mem_req  <= 1'b1;
            state        <= PF_REQ;
          end else
`endif
          if (ir_load) begin
            // Jump wins over a simultaneous fetch: fetch at the target.
            pc           <= issue_addr;
            mem.mem_addr <= issue_addr;
            mem.mem_req  <= 1'b1;
            busy         <= 1'b1;
            state        <= FETCH_REQ;
`ifdef FETCH_PREFETCH_EN
            pf_valid     <= 1'b0;
`endif
          end else if (pc_load) begin
            pc <= pc_in;
`ifdef FETCH_PREFETCH_EN
            pf_valid     <= 1'b0;
            mem.mem_addr <= pc_in;
            mem.mem_req  <= 1'b1;
            state        <= PF_REQ;
`endif
          end
        end

        default: begin
          // A request is in flight; it always runs to its ack.
          if (mem.mem_ack) begin
            jump_pend <= 1'b0;
            if (jump_now) begin
              // Data for the old stream is dropped.
              pc <= jump_tgt;
              if (demand) begin
                busy         <= 1'b1;
                mem.mem_addr <= jump_tgt;
                mem.mem_req  <= 1'b1;
                state        <= FETCH_REQ;
              end else begin
`ifdef FETCH_PREFETCH_EN
                mem.mem_addr <= jump_tgt;
                mem.mem_req  <= 1'b1;
                state        <= PF_REQ;
`else
                mem.mem_req  <= 1'b0;
                state        <= IDLE;
`endif
              end
            end else if (demand) begin
              IR       <= mem.mem_data;
              ir_valid <= 1'b1;
              pc       <= pc_inc;
              busy     <= 1'b0;
`ifdef FETCH_PREFETCH_EN
              mem.mem_addr <= pc_inc;
              mem.mem_req  <= 1'b1;
              state        <= PF_REQ;
`else
              mem.mem_req  <= 1'b0;
              state        <= IDLE;
`endif
            end
`ifdef FETCH_PREFETCH_EN
            else begin
              pf_data     <= mem.mem_data;
              pf_valid    <= 1'b1;
              mem.mem_req <= 1'b0;
              state       <= IDLE;
            end
`endif
          end else begin
            // Latest target wins if several jumps arrive before the ack.
            if (pc_load) begin
              jump_pend   <= 1'b1;
              jump_target <= pc_in;
            end
`ifdef FETCH_PREFETCH_EN
            if (demand) busy <= 1'b1;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Program memory returns
// addr+1 for every address, so mem[00]=01, mem[40]=41, mem[FF]=00.
module tb_fetch_unit;

  logic       clock;
  logic       reset;
  logic       ir_load;
  logic       pc_load;
  logic [7:0] pc_in;
  logic [7:0] IR;
  logic       ir_valid;
  logic [7:0] pc;
  logic       busy;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.ADDR_WIDTH(8)) bus ();

  fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(0)) dut (
    .clock    (clock),
    .reset    (reset),
    .ir_load  (ir_load),
    .pc_load  (pc_load),
    .pc_in    (pc_in),
    .mem      (bus),
    .IR       (IR),
    .ir_valid (ir_valid),
    .pc       (pc),
    .busy     (busy)
  );

  assign bus.mem_data = bus.mem_addr + 8'h01;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_in       = 8'h00;
    bus.mem_ack = 1'b0;

    #2;
    check("rst_mem_req",  32'(bus.mem_req),  32'h0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_pc",       32'(pc),           32'h0);
    check("rst_ir",       32'(IR),           32'h0);
    check("rst_busy",     32'(busy),         32'h0);
    check("rst_ir_valid", 32'(ir_valid),     32'h0);
    #10 reset = 1'b1;
    tick();

`ifndef FETCH_PREFETCH_EN
    // Zero-wait fetch from address 0.
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    check("t1_req",  32'(bus.mem_req),  32'h1);
    check("t1_addr", 32'(bus.mem_addr), 32'h0);
    check("t1_busy", 32'(busy),         32'h1);
    check("t1_ir_early", 32'(IR),       32'h0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("t1_ir",    32'(IR),          32'h01);
    check("t1_valid", 32'(ir_valid),    32'h1);
    check("t1_pc",    32'(pc),          32'h01);
    check("t1_busy0", 32'(busy),        32'h0);
    check("t1_req0",  32'(bus.mem_req), 32'h0);
    tick();
    check("t1_valid_pulse", 32'(ir_valid), 32'h0);

    // Ack delayed 3 cycles from address 0; a second ir_load is ignored.
    pc_load = 1'b1;
    pc_in   = 8'h00;
    tick();
    pc_load = 1'b0;
    check("t2_pc_jump", 32'(pc), 32'h0);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_req",  32'(bus.mem_req),  32'h1);
      check("t2_addr", 32'(bus.mem_addr), 32'h0);
      check("t2_busy", 32'(busy),         32'h1);
      check("t2_valid_hold", 32'(ir_valid), 32'h0);
      if (i == 1) ir_load = 1'b1;
      if (i == 3) bus.mem_ack = 1'b1;
      tick();
      ir_load = 1'b0;
    end
    bus.mem_ack = 1'b0;
    check("t2_valid", 32'(ir_valid),    32'h1);
    check("t2_pc",    32'(pc),          32'h01);
    check("t2_req0",  32'(bus.mem_req), 32'h0);
    tick();
    check("t2_no_second_fetch", 32'(bus.mem_req), 32'h0);

    // PC wrap from FF.
    pc_load = 1'b1;
    pc_in   = 8'hFF;
    tick();
    pc_load = 1'b0;
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    check("t3_addr", 32'(bus.mem_addr), 32'hFF);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("t3_ir", 32'(IR), 32'h00);
    check("t3_pc", 32'(pc), 32'h00);

    // Jump while a fetch from 05 is in flight; second target overrides.
    IR_preset: begin
      pc_load = 1'b1;
      pc_in   = 8'h05;
      tick();
      pc_load = 1'b0;
      ir_load = 1'b1;
      tick();
      ir_load = 1'b0;
      check("t4_addr05", 32'(bus.mem_addr), 32'h05);
      pc_load = 1'b1;
      pc_in   = 8'h30;
      tick();
      pc_in   = 8'h40;
      tick();
      pc_load = 1'b0;
      check("t4_addr_stable", 32'(bus.mem_addr), 32'h05);
      check("t4_pc_hold",     32'(pc),           32'h05);
      bus.mem_ack = 1'b1;
      tick();
      check("t4_ir_keep",   32'(IR),           32'h00);
      check("t4_no_valid",  32'(ir_valid),     32'h0);
      check("t4_pc_tgt",    32'(pc),           32'h40);
      check("t4_refetch",   32'(bus.mem_req),  32'h1);
      check("t4_addr40",    32'(bus.mem_addr), 32'h40);
      check("t4_busy",      32'(busy),         32'h1);
      tick();
      bus.mem_ack = 1'b0;
      check("t4_ir",    32'(IR),       32'h41);
      check("t4_valid", 32'(ir_valid), 32'h1);
      check("t4_pc",    32'(pc),       32'h41);
      check("t4_busy0", 32'(busy),     32'h0);
    end

    // Reset in the middle of a request; a late ack does nothing.
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    check("t5_req", 32'(bus.mem_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("t5_req_async", 32'(bus.mem_req),  32'h0);
    check("t5_pc",        32'(pc),           32'h0);
    check("t5_ir",        32'(IR),           32'h0);
    check("t5_busy",      32'(busy),         32'h0);
    check("t5_addr",      32'(bus.mem_addr), 32'h0);
    bus.mem_ack = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("t5_late_ir",    32'(IR),          32'h0);
    check("t5_late_valid", 32'(ir_valid),    32'h0);
    check("t5_late_req",   32'(bus.mem_req), 32'h0);
    check("t5_late_pc",    32'(pc),          32'h0);
`else
    // Demand fetch, then prefetch, then a one-edge delivery from the buffer.
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("p1_ir",     32'(IR),           32'h01);
    check("p1_pc",     32'(pc),           32'h01);
    check("p1_pf_req", 32'(bus.mem_req),  32'h1);
    check("p1_pf_addr",32'(bus.mem_addr), 32'h01);
    check("p1_busy",   32'(busy),         32'h0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("p2_idle",   32'(bus.mem_req),  32'h0);
    check("p2_pc",     32'(pc),           32'h01);
    check("p2_ir",     32'(IR),           32'h01);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    check("p3_ir",     32'(IR),           32'h02);
    check("p3_valid",  32'(ir_valid),     32'h1);
    check("p3_busy",   32'(busy),         32'h0);
    check("p3_pc",     32'(pc),           32'h02);
    check("p3_pf_addr",32'(bus.mem_addr), 32'h02);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("p4_idle", 32'(bus.mem_req), 32'h0);
    // Jump clears the buffer: the next ir_load must go out as a demand.
    pc_load = 1'b1;
    pc_in   = 8'h10;
    tick();
    pc_load = 1'b0;
    check("p5_pc",   32'(pc),           32'h10);
    check("p5_req",  32'(bus.mem_req),  32'h1);
    check("p5_addr", 32'(bus.mem_addr), 32'h10);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    check("p6_busy", 32'(busy), 32'h1);
    check("p6_ir",   32'(IR),   32'h02);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("p7_ir",    32'(IR),       32'h11);
    check("p7_valid", 32'(ir_valid), 32'h1);
    check("p7_pc",    32'(pc),       32'h11);
    check("p7_busy",  32'(busy),     32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
